bcd_updown_counter: RTL and testbench
=====================================

Name: bcd_updown_counter

Overview:
Parametrised multi-digit synchronous BCD (decade) counter, the successor of the single-digit 0–9 counter. It adds:
- DIGITS cascaded decades
- up/down direction
- count enable
- synchronous clear and parallel load with BCD validity checking
- terminal-count/carry output for chaining further instances
- a sticky wrap flag

Used as the event/time counter feeding seven-segment display and timer blocks.

Parameters:
DIGITS, 4, number of cascaded BCD decades (1–8); counter range 0 .. 10^DIGITS-1

Ports:
clk  input  1  rising-edge clock
rstn  input  1  asynchronous active-low reset
en  input  1  count enable; one step per clock while high
up  input  1  direction: 1 = increment, 0 = decrement
clr  input  1  synchronous clear to zero
load  input  1  synchronous parallel load
load_val  input  4*DIGITS  BCD load value; digit i = bits [4i+3:4i]
wrap_ack  input  1  clears the sticky wrap flag
q  output  4*DIGITS  counter value, BCD; digit 0 is least significant
tc  output  1  terminal count (combinational)
cout  output  1  chain carry/borrow = en & tc (combinational)
wrap  output  1  sticky: counter has wrapped since last clear/ack
load_err  output  1  one-cycle pulse: load rejected because of an invalid digit

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk.
  - While rstn=0: q=0, wrap=0, load_err=0, regardless of clk.
  - Release is synchronous to the next rising clk edge.
- Priority per rising edge: clr > load > en. Lower-priority actions are ignored in the same cycle.
- clr=1:
  - q <= 0, wrap <= 0, load_err <= 0.
- load=1 (clr=0):
  - If every digit of load_val is ≤ 9: q <= load_val, load_err <= 0.
  - Else: q is unchanged and load_err <= 1 for exactly one cycle.
  - wrap is unaffected.
- en=1, up=1 (no clr/load):
  - Digit 0 increments.
  - Digit i increments only when all lower digits are 9; a digit at 9 goes to 0.
  - From all-9s, q goes to all-0s and wrap <= 1.
- en=1, up=0:
  - Digit 0 decrements.
  - Digit i decrements only when all lower digits are 0; a digit at 0 goes to 9.
  - From all-0s, q goes to all-9s and wrap <= 1.
- en=0 (no clr/load): q holds.
- Latency: one clock from input to q. There is no pipeline, so q always holds a valid BCD value after reset.
- tc:
  - up=1: tc = (q == all 9s).
  - up=0: tc = (q == all 0s).
  - tc is independent of en.
- cout = en & tc. It is asserted in the cycle before the wrap edge. Connect it to the en input of the next-higher instance, with up shared, for ripple-free cascading.
- wrap:
  - Set on any wrap edge.
  - Cleared by clr, or by wrap_ack when no wrap occurs in the same cycle. A simultaneous wrap and wrap_ack leaves wrap=1 (set wins).
- load_err: cleared on every edge where no invalid load occurs.
- Direction may change on any cycle. The step uses the up value sampled at that edge.
- rstn asserted mid-count: q goes to 0 immediately, with no clock needed.
- DIGITS=1 behaves as the original single-decade counter, with cout as its carry.

Test Plan:
1. DIGITS=2, rstn=0 for 2 clk, release, en=1, up=1 for 100 clk → q steps 00,01..09,10..99,00. cout=1 only during the q=99 cycle; wrap=1 after the 99→00 edge.
2. en=1, up=0 from q=00 → next q=99 and wrap=1. From q=10 → q=09. Check tc=1 at q=00 with up=0.
3. load=1, load_val=8'h47 → q=47, load_err=0. Then load_val=8'h4A → q stays 47, load_err pulses for 1 cycle.
4. clr=1, load=1, en=1 simultaneously with q=55 → q=00, wrap=0. Then load=1, en=1 with load_val=8'h12 → q=12 (load beats count).
5. wrap=1, then wrap_ack=1 on the same edge as a 99→00 wrap → wrap remains 1. Next edge, wrap_ack=1 with no wrap → wrap=0.
6. Two DIGITS=1 instances chained via cout→en, counting up 0→23. Then assert rstn=0 asynchronously between clock edges → both q=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter
//
// Multi-decade synchronous BCD up/down counter with count enable, synchronous
// clear, validated parallel load, terminal-count / chain-carry output and a
// sticky wrap flag. It feeds seven-segment display and timer blocks.
//
// Parameters
//   DIGITS    number of cascaded BCD decades (1..8); range 0 .. 10^DIGITS-1
//
// Ports
//   clk       rising-edge clock
//   rstn      asynchronous active-low reset (q, wrap, load_err -> 0)
//   en        count enable, one step per clock while high
//   up        direction: 1 = increment, 0 = decrement
//   clr       synchronous clear (highest priority)
//   load      synchronous parallel load (beats en)
//   load_val  BCD load value, digit i = bits [4i+3:4i]
//   wrap_ack  clears the sticky wrap flag (a wrap in the same cycle wins)
//   q         counter value, BCD, digit 0 least significant
//   tc        terminal count: all 9s when counting up, all 0s when down
//   cout      chain carry/borrow = en & tc, drives en of the next instance
//   wrap      sticky: counter has wrapped since the last clear/ack
//   load_err  one-cycle pulse: load rejected because a digit exceeded 9
// -----------------------------------------------------------------------------
module bcd_updown_counter #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  en,
   input  logic                  up,
   input  logic                  clr,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  wrap_ack,
   output logic [4*DIGITS-1:0]   q,
   output logic                  tc,
   output logic                  cout,
   output logic                  wrap,
   output logic                  load_err
);

   localparam int W = 4 * DIGITS;

   logic [W-1:0] r_q;
   logic         r_wrap;
   logic         r_load_err;

   logic [W-1:0] w_q_step;
   logic         w_all9;
   logic         w_all0;
   logic         w_load_ok;
   logic         w_tc;
   logic         w_wrap_evt;

   // Next count value and whole-counter flags. w_all9 / w_all0 are built up
   // as a running prefix: while processing digit i they describe digits
   // 0..i-1, which is exactly the condition for digit i to step.
   always_comb begin
      // NOTE: every signal driven here is given a default before any
      // conditional assignment, so no path leaves it unassigned (no latch).
      w_q_step  = r_q;
      w_all9    = 1'b1;
      w_all0    = 1'b1;
      w_load_ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (up && w_all9) begin
            w_q_step[4*i +: 4] = (r_q[4*i +: 4] == 4'd9) ? 4'd0 : r_q[4*i +: 4] + 4'd1;
         end else if (!up && w_all0) begin
            w_q_step[4*i +: 4] = (r_q[4*i +: 4] == 4'd0) ? 4'd9 : r_q[4*i +: 4] - 4'd1;
         end
         w_all9 = w_all9 & (r_q[4*i +: 4] == 4'd9);
         w_all0 = w_all0 & (r_q[4*i +: 4] == 4'd0);
         if (load_val[4*i +: 4] > 4'd9) begin
            w_load_ok = 1'b0;
         end
      end
   end

   assign w_tc = up ? w_all9 : w_all0;

   // A wrap edge is a counting step taken from the terminal value; clr and
   // load suppress counting, so they also suppress the wrap.
   assign w_wrap_evt = en & w_tc & ~clr & ~load;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_q <= '0;
      end else if (clr) begin
         r_q <= '0;
      end else if (load) begin
         if (w_load_ok) begin
            r_q <= load_val;
         end
      end else if (en) begin
         r_q <= w_q_step;
      end
   end

   // Wrap is independent of load: only clr, a wrap edge or wrap_ack touch it,
   // and a wrap edge overrides a simultaneous acknowledge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wrap <= 1'b0;
      end else if (clr) begin
         r_wrap <= 1'b0;
      end else if (w_wrap_evt) begin
         r_wrap <= 1'b1;
      end else if (wrap_ack) begin
         r_wrap <= 1'b0;
      end
   end

   // Single-cycle pulse: set only on a rejected load, cleared on every other edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_load_err <= 1'b0;
      end else begin
         r_load_err <= ~clr & load & ~w_load_ok;
      end
   end

   assign q        = r_q;
   assign tc       = w_tc;
   assign cout     = en & w_tc;
   assign wrap     = r_wrap;
   assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_updown_counter
//
// Self-checking bench. A DIGITS=2 instance is compared against an integer
// model (value 0..99 with modular arithmetic); two DIGITS=1 instances are
// chained through cout -> en and compared against a plain event count.
// -----------------------------------------------------------------------------
module tb_bcd_updown_counter;

   localparam int D2  = 2;
   localparam int MAX = 99;

   logic clk;
   logic rstn;

   // DIGITS=2 instance
   logic        en, up, clr, load, wrap_ack;
   logic [7:0]  load_val;
   logic [7:0]  q;
   logic        tc, cout, wrap, load_err;

   // chained DIGITS=1 pair
   logic        c_rstn, c_en, c_up;
   logic [3:0]  q_lo, q_hi;
   logic        tc_lo, tc_hi, cout_lo, cout_hi;
   logic        wrap_lo, wrap_hi, err_lo, err_hi;

   int n_checks;
   int n_errors;

   // behavioural model state
   int m_val;
   bit m_wrap;
   bit m_err;

   bcd_updown_counter #(.DIGITS(D2)) dut (
      .clk(clk), .rstn(rstn), .en(en), .up(up), .clr(clr), .load(load),
      .load_val(load_val), .wrap_ack(wrap_ack), .q(q), .tc(tc), .cout(cout),
      .wrap(wrap), .load_err(load_err)
   );

   bcd_updown_counter #(.DIGITS(1)) u_lo (
      .clk(clk), .rstn(c_rstn), .en(c_en), .up(c_up), .clr(1'b0), .load(1'b0),
      .load_val(4'd0), .wrap_ack(1'b0), .q(q_lo), .tc(tc_lo), .cout(cout_lo),
      .wrap(wrap_lo), .load_err(err_lo)
   );

   bcd_updown_counter #(.DIGITS(1)) u_hi (
      .clk(clk), .rstn(c_rstn), .en(cout_lo), .up(c_up), .clr(1'b0), .load(1'b0),
      .load_val(4'd0), .wrap_ack(1'b0), .q(q_hi), .tc(tc_hi), .cout(cout_hi),
      .wrap(wrap_hi), .load_err(err_hi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model helpers ----------------
   function automatic int bcd2int(input logic [7:0] v);
      return int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic logic [7:0] int2bcd(input int v);
      logic [7:0] r;
      r[7:4] = 4'(v / 10);
      r[3:0] = 4'(v % 10);
      return r;
   endfunction

   function automatic bit bcd_valid(input logic [7:0] v);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
   endfunction

   function automatic bit m_tc();
      return up ? (m_val == MAX) : (m_val == 0);
   endfunction

   // Apply one clock edge to the model using the currently driven inputs.
   task automatic model_update();
      bit wrapped;
      wrapped = 1'b0;
      if (clr) begin
         m_val  = 0;
         m_wrap = 1'b0;
         m_err  = 1'b0;
      end else begin
         m_err = 1'b0;
         if (load) begin
            if (bcd_valid(load_val)) m_val = bcd2int(load_val);
            else                     m_err = 1'b1;
         end else if (en) begin
            if (up) begin
               wrapped = (m_val == MAX);
               m_val   = (m_val + 1) % (MAX + 1);
            end else begin
               wrapped = (m_val == 0);
               m_val   = (m_val + MAX) % (MAX + 1);
            end
         end
         if (wrapped)       m_wrap = 1'b1;
         else if (wrap_ack) m_wrap = 1'b0;
      end
   endtask

   task automatic drive(input bit i_en, input bit i_up, input bit i_clr,
                        input bit i_load, input logic [7:0] i_lv, input bit i_ack);
      en = i_en; up = i_up; clr = i_clr; load = i_load;
      load_val = i_lv; wrap_ack = i_ack;
   endtask

   // Advance one clock; model follows the edge; leave #1 after the edge.
   task automatic clock_edge();
      @(posedge clk);
      model_update();
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rstn = 1'b0; c_rstn = 1'b0; c_en = 1'b0; c_up = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      m_val = 0; m_wrap = 1'b0; m_err = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (q !== 8'h00 || wrap !== 1'b0 || load_err !== 1'b0) begin
         n_errors++;
         $display("FAIL reset: q=%h wrap=%b load_err=%b, want q=00 wrap=0 load_err=0", q, wrap, load_err);
      end
      n_checks++;
      if (q_lo !== 4'd0 || q_hi !== 4'd0) begin
         n_errors++;
         $display("FAIL reset_chain: q_hi=%h q_lo=%h, want 0 0", q_hi, q_lo);
      end
      rstn = 1'b1;
   endtask

   task automatic test_count_up();
      // rstn released at posedge+1; first counting edge is the next one
      for (int k = 1; k <= 100; k++) begin
         n_checks++;
         if (cout !== (en & m_tc())) begin
            n_errors++;
            $display("FAIL up_cout step %0d: cout=%b want %b (q=%h)", k, cout, en & m_tc(), q);
         end
         clock_edge();
         n_checks++;
         if (q !== int2bcd(k % 100) || wrap !== m_wrap) begin
            n_errors++;
            $display("FAIL up_q step %0d: q=%h wrap=%b want q=%h wrap=%b", k, q, wrap, int2bcd(k % 100), m_wrap);
         end
      end
      n_checks++;
      if (q !== 8'h00 || wrap !== 1'b1) begin
         n_errors++;
         $display("FAIL up_wrap_end: q=%h wrap=%b want q=00 wrap=1", q, wrap);
      end
   endtask

   task automatic test_count_down();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      clock_edge();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      #1;
      n_checks++;
      if (tc !== 1'b1 || cout !== 1'b1) begin
         n_errors++;
         $display("FAIL down_tc_at_00: tc=%b cout=%b want 1 1", tc, cout);
      end
      clock_edge();
      n_checks++;
      if (q !== 8'h99 || wrap !== 1'b1) begin
         n_errors++;
         $display("FAIL down_00_to_99: q=%h wrap=%b want q=99 wrap=1", q, wrap);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0);
      clock_edge();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      clock_edge();
      n_checks++;
      if (q !== 8'h09) begin
         n_errors++;
         $display("FAIL down_10_to_09: q=%h want 09", q);
      end
   endtask

   task automatic test_load();
      drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h47, 1'b0);
      clock_edge();
      n_checks++;
      if (q !== 8'h47 || load_err !== 1'b0) begin
         n_errors++;
         $display("FAIL load_valid: q=%h load_err=%b want q=47 load_err=0", q, load_err);
      end
      drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h4A, 1'b0);
      clock_edge();
      n_checks++;
      if (q !== 8'h47 || load_err !== 1'b1) begin
         n_errors++;
         $display("FAIL load_invalid: q=%h load_err=%b want q=47 load_err=1", q, load_err);
      end
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      clock_edge();
      n_checks++;
      if (q !== 8'h47 || load_err !== 1'b0) begin
         n_errors++;
         $display("FAIL load_err_pulse: q=%h load_err=%b want q=47 load_err=0", q, load_err);
      end
   endtask

   task automatic test_priority();
      drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0);
      clock_edge();
      drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 1'b0);
      clock_edge();
      n_checks++;
      if (q !== 8'h00 || wrap !== 1'b0) begin
         n_errors++;
         $display("FAIL clr_priority: q=%h wrap=%b want q=00 wrap=0", q, wrap);
      end
      drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 1'b0);
      clock_edge();
      n_checks++;
      if (q !== 8'h12) begin
         n_errors++;
         $display("FAIL load_beats_count: q=%h want 12", q);
      end
   endtask

   task automatic test_wrap_ack();
      drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h99, 1'b0);
      clock_edge();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      clock_edge();
      drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h99, 1'b0);
      clock_edge();
      n_checks++;
      if (wrap !== 1'b1 || q !== 8'h99) begin
         n_errors++;
         $display("FAIL wrap_setup: q=%h wrap=%b want q=99 wrap=1", q, wrap);
      end
      drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      clock_edge();
      n_checks++;
      if (wrap !== 1'b1 || q !== 8'h00) begin
         n_errors++;
         $display("FAIL wrap_set_wins: q=%h wrap=%b want q=00 wrap=1", q, wrap);
      end
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      clock_edge();
      n_checks++;
      if (wrap !== 1'b0) begin
         n_errors++;
         $display("FAIL wrap_ack_clears: wrap=%b want 0", wrap);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 15) == 0,
               $urandom_range(0, 7) == 0, 8'($urandom), $urandom_range(0, 7) == 0);
         #1;
         n_checks++;
         if (tc !== m_tc() || cout !== (en & m_tc())) begin
            n_errors++;
            $display("FAIL rand_tc %0d: tc=%b cout=%b want tc=%b cout=%b (q=%h up=%b)",
                     k, tc, cout, m_tc(), en & m_tc(), q, up);
         end
         clock_edge();
         n_checks++;
         if (q !== int2bcd(m_val) || wrap !== m_wrap || load_err !== m_err) begin
            n_errors++;
            $display("FAIL rand_state %0d: q=%h wrap=%b load_err=%b want q=%h wrap=%b load_err=%b",
                     k, q, wrap, load_err, int2bcd(m_val), m_wrap, m_err);
         end
      end
   endtask

   task automatic test_chain();
      logic [7:0] got;
      @(posedge clk);
      #1;
      c_rstn = 1'b1;
      c_up   = 1'b1;
      c_en   = 1'b1;
      for (int k = 1; k <= 23; k++) begin
         @(posedge clk);
         #1;
         got = {q_hi, q_lo};
         n_checks++;
         if (got !== int2bcd(k)) begin
            n_errors++;
            $display("FAIL chain_count %0d: q_hi:q_lo=%h want %h", k, got, int2bcd(k));
         end
      end
      // asynchronous reset between edges: takes effect with no clock edge
      @(posedge clk);
      #3;
      c_rstn = 1'b0;
      #1;
      n_checks++;
      if (q_lo !== 4'd0 || q_hi !== 4'd0) begin
         n_errors++;
         $display("FAIL chain_async_reset: q_hi=%h q_lo=%h want 0 0", q_hi, q_lo);
      end
      c_en = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      test_reset();
      test_count_up();
      test_count_down();
      test_load();
      test_priority();
      test_wrap_ack();
      test_random();
      test_chain();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
